// File: rtl/dsp_systolic_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_systolic_pkg : shared widths and FIFO entry layout for the accumulator
// Revision: 1.0
// ---------------------------------------------------------------------------
package dsp_systolic_pkg;

  localparam int c_RESULT_A_WIDTH = 64;
  localparam int c_ACC_WIDTH      = 80;
  localparam int c_CNT_WIDTH      = 16;
  localparam int c_FIFO_DEPTH     = 4;

  typedef struct packed {
    logic [c_ACC_WIDTH-1:0] data;
    logic [c_CNT_WIDTH-1:0] count;
    logic                   trunc;
  } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/dsp_sc_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_sc_fifo : synchronous show-ahead FIFO, push accepted on full when popping
// Revision: 1.0
// ---------------------------------------------------------------------------
module dsp_sc_fifo
  import dsp_systolic_pkg::*;
#(
  parameter int WIDTH = 97,
  parameter int DEPTH = c_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW:0]    r_wr_ptr;
  logic [c_AW:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + {{c_AW{1'b0}}, 1'b1};
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + {{c_AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/dsp_systolic_27x27s_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dsp_systolic_27x27s_acc : groups systolic partial sums and queues the totals
// Revision: 1.0
// ---------------------------------------------------------------------------
module dsp_systolic_27x27s_acc
  import dsp_systolic_pkg::*;
#(
  parameter int RESULT_A_WIDTH = c_RESULT_A_WIDTH,
  parameter int ACC_WIDTH      = c_ACC_WIDTH,
  parameter int CNT_WIDTH      = c_CNT_WIDTH,
  parameter int FIFO_DEPTH     = c_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      in_last,
  input  logic [RESULT_A_WIDTH-1:0] result,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_WIDTH-1:0]      out_data,
  output logic [CNT_WIDTH-1:0]      out_count,
  output logic                      out_trunc,
  output logic                      ovf_sticky,
  input  logic                      clr_ovf
);

  localparam int c_ENT_W = ACC_WIDTH + CNT_WIDTH + 1;

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 r_first;
  logic                 r_ovf;

  logic [ACC_WIDTH-1:0] w_sext;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [CNT_WIDTH-1:0] w_cnt_next;
  logic                 w_close;
  logic                 w_trunc;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_drop;
  logic [c_ENT_W-1:0]   w_wdata;
  logic [c_ENT_W-1:0]   w_rdata;
  logic [ACC_WIDTH-1:0] w_hd_data;
  logic [CNT_WIDTH-1:0] w_hd_cnt;
  logic                 w_hd_trunc;

  assign w_sext     = ACC_WIDTH'($signed(result));
  assign w_acc_next = (r_first ? '0 : r_acc) + w_sext;
  assign w_cnt_next = r_first ? CNT_WIDTH'(1) : r_cnt + CNT_WIDTH'(1);
  // A beat that reaches the all-ones count closes the group even without in_last.
  assign w_close    = in_valid & (in_last | (&w_cnt_next));
  assign w_trunc    = ~in_last;
  assign w_push     = w_close & rst_n;
  assign w_pop      = out_valid & out_ready;
  assign w_drop     = w_push & w_full & ~w_pop;
  assign w_wdata    = {w_acc_next, w_cnt_next, w_trunc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_first <= 1'b1;
    end else if (in_valid) begin
      r_acc   <= w_acc_next;
      r_cnt   <= w_cnt_next;
      r_first <= w_close;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  dsp_sc_fifo #(
    .WIDTH (c_ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // FIFO storage is not reset, so the head is masked to zero while empty.
  assign {w_hd_data, w_hd_cnt, w_hd_trunc} = w_rdata;
  assign out_valid  = ~w_empty;
  assign out_data   = out_valid ? w_hd_data  : '0;
  assign out_count  = out_valid ? w_hd_cnt   : '0;
  assign out_trunc  = out_valid ? w_hd_trunc : 1'b0;
  assign ovf_sticky = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dsp_systolic_27x27s_acc.sv
`default_nettype none
// tb_dsp_systolic_27x27s_acc : directed stimulus, queue-based reference model
// and literal spot checks for the grouped accumulator.
module tb_dsp_systolic_27x27s_acc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic [63:0] result = '0;
  logic        out_valid, out_trunc, ovf_sticky;
  logic [79:0] out_data;
  logic [15:0] out_count;

  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_out_ready = 1'b1;
  logic [63:0] b_result = '0;
  logic        b_out_valid, b_out_trunc, b_ovf_sticky;
  logic [79:0] b_out_data;
  logic [3:0]  b_out_count;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  dsp_systolic_27x27s_acc dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .result(result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_count(out_count), .out_trunc(out_trunc),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf)
  );

  dsp_systolic_27x27s_acc #(.CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_last(b_in_last),
    .result(b_result), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_count(b_out_count), .out_trunc(b_out_trunc),
    .ovf_sticky(b_ovf_sticky), .clr_ovf(1'b0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bounded queue of completed groups.
  typedef struct {
    logic [79:0] d;
    int          c;
    bit          t;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_e;
  logic [79:0] m_sum;
  int          m_cnt;
  bit          m_first = 1'b1;
  bit          m_ovf   = 1'b0;
  bit          m_init  = 1'b0;
  bit          m_pop, m_cl, m_full;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_sum = '0; m_cnt = 0; m_first = 1'b1; m_ovf = 1'b0; m_init = 1'b1;
    end else if (m_init) begin
      m_pop  = (mq.size() > 0) && out_ready;
      m_full = (mq.size() == 4);
      m_cl   = 1'b0;
      if (in_valid) begin
        if (m_first) begin m_sum = '0; m_cnt = 0; end
        m_sum = m_sum + {{16{result[63]}}, result};
        m_cnt++;
        if (in_last || m_cnt == 65535) begin
          m_cl = 1'b1; m_e.d = m_sum; m_e.c = m_cnt; m_e.t = !in_last; m_first = 1'b1;
        end else begin
          m_first = 1'b0;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_cl && !(m_full && !m_pop)) mq.push_back(m_e);
      if (m_cl && m_full && !m_pop) m_ovf = 1'b1;
      else if (clr_ovf)             m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmp_valid", out_valid, mq.size() > 0);
      chk("cmp_ovf", ovf_sticky, m_ovf);
      if (mq.size() > 0) begin
        chk("cmp_data", out_data, mq[0].d);
        chk("cmp_count", out_count, mq[0].c[15:0]);
        chk("cmp_trunc", out_trunc, mq[0].t);
      end
    end
  end

  task automatic drive(input logic v, input logic l, input logic [63:0] r, input logic rdy);
    @(negedge clk);
    in_valid = v; in_last = l; result = r; out_ready = rdy;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_trunc", out_trunc, 0);
    chk("rst_ovf", ovf_sticky, 0);
    rst_n = 1'b1;

    // 3-beat group 5, -7, 100
    drive(1, 0, 5, 1); drive(1, 0, -7, 1); drive(1, 1, 100, 1); drive(0, 0, 0, 1);
    chk("g3_valid", out_valid, 1);
    chk("g3_data", out_data, 98);
    chk("g3_count", out_count, 3);
    chk("g3_trunc", out_trunc, 0);

    // one-beat group of -1
    drive(1, 1, -1, 1); drive(0, 0, 0, 1);
    chk("g1_data", out_data, {48'h0, {80{1'b1}}});
    chk("g1_count", out_count, 1);

    // gap inside a group
    drive(1, 0, 7, 1); drive(0, 0, 0, 1); drive(0, 0, 0, 1); drive(1, 1, 8, 1); drive(0, 0, 0, 1);
    chk("gap_data", out_data, 15);
    chk("gap_count", out_count, 2);

    // sum of two max-positive results needs the extra accumulator bits
    drive(1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1); drive(1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    drive(0, 0, 0, 1);
    chk("wide_data", out_data, 80'h0_FFFF_FFFF_FFFF_FFFE);

    // overflow: five groups with the consumer stalled
    for (int i = 1; i <= 5; i++) drive(1, 1, i, 0);
    drive(0, 0, 0, 0);
    chk("ovf_set", ovf_sticky, 1);
    chk("ovf_head", out_data, 1);
    drive(0, 0, 0, 0);
    chk("ovf_hold", out_data, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_drain", out_data, i);
      @(negedge clk);
    end
    chk("ovf_empty", out_valid, 0);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovf_clr", ovf_sticky, 0);

    // push and pop together on a full FIFO
    for (int i = 11; i <= 14; i++) drive(1, 1, i, 0);
    drive(1, 1, 15, 1); drive(0, 0, 0, 1);
    chk("pp_ovf", ovf_sticky, 0);
    for (int i = 12; i <= 15; i++) begin
      chk("pp_order", out_data, i);
      @(negedge clk);
    end
    chk("pp_empty", out_valid, 0);

    // reset mid-group, with in_valid high during reset
    drive(1, 0, 10, 1); drive(1, 0, 20, 1);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; result = 99;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_last = 1'b0; result = 0;
    chk("rstm_valid", out_valid, 0);
    drive(1, 1, 3, 1); drive(0, 0, 0, 1);
    chk("rstm_data", out_data, 3);
    chk("rstm_count", out_count, 1);
    drive(0, 0, 0, 1);

    // CNT_WIDTH=4 instance: force-close at 15 beats
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        chk("trc_valid", b_out_valid, 1);
        chk("trc_data", b_out_data, 15);
        chk("trc_count", b_out_count, 15);
        chk("trc_trunc", b_out_trunc, 1);
      end
      b_in_valid = 1'b1; b_in_last = (i == 17); b_result = 1;
    end
    @(negedge clk);
    b_in_valid = 1'b0; b_in_last = 1'b0; b_result = 0;
    chk("trc2_data", b_out_data, 2);
    chk("trc2_count", b_out_count, 2);
    chk("trc2_trunc", b_out_trunc, 0);
    chk("trc2_ovf", b_ovf_sticky, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_systolic_27x27s_acc.md
DSP_SYSTOLIC_27X27S_ACC -- requirements
Module: dsp_systolic_27x27s_acc

Interface
REQ-001 SHALL have parameter RESULT_A_WIDTH, default 64: width of the incoming systolic-chain result.
REQ-002 SHALL have parameter ACC_WIDTH, default 80: signed accumulator and output width, with ACC_WIDTH >= RESULT_A_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: beat-counter width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries, a power of two, >= 2.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1: result is a valid partial dot product this cycle.
REQ-008 SHALL have port in_last, input, 1: final beat of a group; meaningful only with in_valid.
REQ-009 SHALL have port result, input, RESULT_A_WIDTH: signed systolic-chain output.
REQ-010 SHALL have port out_valid, output, 1: FIFO head holds a completed group.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the head.
REQ-012 SHALL have port out_data, output, ACC_WIDTH: signed group sum.
REQ-013 SHALL have port out_count, output, CNT_WIDTH: number of beats in the group.
REQ-014 SHALL have port out_trunc, output, 1: group was force-closed at the maximum count.
REQ-015 SHALL have port ovf_sticky, output, 1: at least one completed group was dropped.
REQ-016 SHALL have port clr_ovf, input, 1: clears ovf_sticky.

Function
REQ-017 SHALL sign-extend result to ACC_WIDTH before adding.
REQ-018 SHALL compute acc_next = (first beat of group ? 0 : acc) + sext(result) on every in_valid beat; the sum wraps modulo 2^ACC_WIDTH and there is no saturation.
REQ-019 SHALL increment the beat count on every in_valid beat; the first beat of a group sets the count to 1.
REQ-020 SHALL close the group on in_valid and in_last, pushing {acc_next, count, trunc=0} and returning to the first-beat state.
REQ-021 SHALL, when the count reaches 2^CNT_WIDTH-1 without in_last, force-close the group on that beat with trunc=1; the next beat starts a new group.
REQ-022 SHALL treat in_valid with in_last on the first beat as a one-beat group: out_data = sext(result), out_count = 1.
REQ-023 SHALL hold the accumulator and count unchanged on cycles where in_valid is low; gaps inside a group are allowed.
REQ-024 SHALL have no input backpressure, because the upstream chain is free-running.
REQ-025 SHALL, when a group closes while the FIFO is full and no pop occurs that cycle, drop the group and set ovf_sticky; the FIFO contents are unaffected.
REQ-026 SHALL, when a push and a pop occur in the same cycle on a full FIFO, accept the push; this is not an overflow.
REQ-027 SHALL assert out_valid in the cycle after the closing beat when the FIFO was empty (push-to-valid latency 1).
REQ-028 SHALL keep out_data, out_count and out_trunc stable while out_valid is high and out_ready is low.
REQ-029 SHALL pop the FIFO on out_valid and out_ready.
REQ-030 SHALL give clr_ovf priority below a same-cycle drop: the drop sets ovf_sticky, which stays 1.

Reset
REQ-031 SHALL, with rst_n low at a clock edge, force these values: out_valid=0, out_data=0, out_count=0, out_trunc=0, ovf_sticky=0, FIFO empty, accumulator=0, first-beat state.
REQ-032 SHALL discard any group in progress when reset is applied mid-group; no partial sum is emitted.
REQ-033 SHALL ignore in_valid while rst_n is low.

Structure
REQ-034 SHALL place the default widths (RESULT_A_WIDTH, ACC_WIDTH, CNT_WIDTH, FIFO_DEPTH) and the FIFO entry struct {data, count, trunc} in the shared package dsp_systolic_pkg.
REQ-035 SHALL instantiate one sub-module, dsp_sc_fifo: a synchronous show-ahead FIFO with full/empty flags and simultaneous push and pop support.

Verification
REQ-036 SHALL cover a group of 3 beats with results 5, -7, 100 and in_last on the third -> one output: out_data=98, out_count=3, out_trunc=0, out_valid high 1 cycle after the last beat.
REQ-037 SHALL cover a one-beat group with result=-1 and in_last -> out_data = all-ones (-1 in 80 bits), out_count=1.
REQ-038 SHALL cover out_ready=0 with 5 one-beat groups (values 1..5) -> FIFO holds 1..4, the fifth is dropped, ovf_sticky=1; then out_ready=1 pops 1,2,3,4 in order.
REQ-039 SHALL cover a full FIFO with out_ready=1 in the same cycle as a closing beat -> no overflow, and all values emerge in order.
REQ-040 SHALL cover rst_n pulsed low after 2 beats (10, 20), then a new group with 3 and in_last -> output out_data=3, out_count=1.
REQ-041 SHALL cover CNT_WIDTH=4 with 16 beats of value 1 and no in_last -> first output out_data=15, out_count=15, out_trunc=1; the remaining beat opens a new group.
